// File: rtl/dmem_store_buffer.sv
// Store buffer between the core MEM-stage memory port and a single-port dmem.
// Define STORE_BUF_FWD_EN to forward pending store data to loads; otherwise loads stall until drained.
module dmem_store_buffer #(
    parameter int N     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  cpu_addr,
    input  logic [N-1:0]  cpu_writeData,
    input  logic          cpu_writeEnable,
    input  logic          cpu_readEnable,
    output logic [N-1:0]  cpu_readData,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_address,
    output logic [N-1:0]  mem_writeData,
    output logic          mem_memWrite,
    output logic          mem_memRead,
    input  logic [N-1:0]  mem_readData
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [N-1:0]  data_q [DEPTH];

    logic          full;
    logic          push;
    logic          drain;
    logic [AW-1:0] cpu_idx;
    logic          unused_addr_bits;

    assign cpu_idx          = cpu_addr[AW+2:3];
    assign unused_addr_bits = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};

    always_comb begin
        full  = (count_q == DEPTH_C);
        empty = (count_q == '0);
        push  = cpu_writeEnable & ~full;
`ifdef STORE_BUF_FWD_EN
        drain       = ~empty & ~cpu_readEnable & (~cpu_writeEnable | full);
        stall       = cpu_writeEnable & full;
        mem_memRead = cpu_readEnable;
`else
        // A load waits behind pending stores; the port drains them meanwhile.
        drain       = ~empty & (cpu_readEnable | ~cpu_writeEnable | full);
        stall       = (cpu_writeEnable & full) | (cpu_readEnable & ~empty);
        mem_memRead = cpu_readEnable & empty;
`endif
        mem_memWrite  = drain;
        mem_address   = mem_memRead ? cpu_idx : addr_q[head_q];
        mem_writeData = data_q[head_q];

        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = push  ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (drain) begin
            count_d = count_q - (PW + 1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= cpu_idx;
            data_q[tail_q] <= cpu_writeData;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk oldest to newest so the most recently pushed match wins.
    always_comb begin
        cpu_readData = mem_readData;
        fwd_idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (((PW + 1)'(i) < count_q) && (addr_q[fwd_idx] == cpu_idx)) begin
                cpu_readData = data_q[fwd_idx];
            end
        end
    end
`else
    assign cpu_readData = mem_readData;
`endif

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Store buffer between the pipelined core's data-memory port and the single-port `dmem`. Stores from the MEM stage are queued and retired to `dmem` in cycles when the core does not use the memory port. Loads are serviced by `dmem`, with store-to-load forwarding from pending entries. It keeps back-to-back stores from blocking on memory, and exposes `empty` so the memory dump runs only on a fully drained memory.

## Interface
Parameters:
- `N`, 64, data width in bits
- `DEPTH`, 4, entries; power of two, ≥2
- `AW`, 6, dmem word-index width; word index = `cpu_addr[AW+2:3]`

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all queue state
- `cpu_addr`  in  N  byte address from core (DM_addr)
- `cpu_writeData`  in  N  store data
- `cpu_writeEnable`  in  1  store request
- `cpu_readEnable`  in  1  load request; never asserted together with `cpu_writeEnable`
- `cpu_readData`  out  N  load data, combinational
- `stall`  out  1  core must hold current MEM-stage instruction
- `empty`  out  1  no pending stores
- `mem_address`  out  AW  dmem word index
- `mem_writeData`  out  N  dmem write data
- `mem_memWrite`  out  1  dmem write enable (write on rising `clk`)
- `mem_memRead`  out  1  dmem read enable
- `mem_readData`  in  N  dmem read data, combinational from `mem_address`

## Operation
- State is a circular queue:
  - `head`/`tail` pointers, log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, 0..DEPTH.
  - Each entry holds {word index AW, data N}.
- Push condition: `cpu_writeEnable & ~full`.
  - On push, the entry at `tail` ← {`cpu_addr[AW+2:3]`, `cpu_writeData`}, and `tail`++.
- Drain condition: `~empty & ~cpu_readEnable & (~cpu_writeEnable | full)`.
  - While draining: `mem_memWrite`=1, `mem_address`/`mem_writeData` = head entry.
  - On the clock edge, `head`++.
- Push and drain are mutually exclusive in a cycle, because a drain with a store present requires `full`, which blocks the push.
- `count` update: +1 on push, −1 on drain.
- Full store: `stall` = `cpu_writeEnable & full`.
  - The head entry drains that cycle, and the store is accepted the next cycle.
- Load (`cpu_readEnable`=1):
  - `mem_memRead`=1, `mem_address`=`cpu_addr[AW+2:3]`, no drain.
  - `cpu_readData` = data of the newest valid entry whose index matches, else `mem_readData`.
- Idle (no load, no drain): `mem_memRead`=0, `mem_memWrite`=0, `mem_address`=head index.
- `empty` = (`count`==0). `full` = (`count`==DEPTH).
- Reset (async, any time):
  - `head`=`tail`=`count`=0, so `empty`=1, `stall`=0, `mem_memWrite`=0.
  - Pending stores are discarded. Entry storage is not cleared.

## Timing
- Push is registered at the clock edge. The new entry is visible to forwarding in the next cycle.
- Minimum store-to-memory latency is 1 cycle: accepted at edge k, written to dmem at edge k+1 if that cycle is idle.
- `stall`, `cpu_readData`, and all `mem_*` outputs are combinational from inputs and queue state. No output is registered.
- A stall lasts exactly one cycle per blocked store, since the forced drain frees one entry.
- Pointer wrap: after DEPTH pushes, `tail` returns to 0. Ordering is preserved across the wrap.
- Forwarding priority: among matching entries, the most recently pushed one (closest to `tail`) wins.

## Configuration
- `STORE_BUF_FWD_EN` defined:
  - Forwarding as described; loads never stall.
- Undefined:
  - A load with `~empty` asserts `stall`=1, `mem_memRead`=0, and the memory port drains the head entry instead.
  - The load proceeds in the first cycle with `empty`=1, and `cpu_readData` = `mem_readData`.

## Test plan
- **Reset:** pulse `reset` mid-clock.
  - `empty`=1, `stall`=0, `mem_memWrite`=0, `mem_memRead`=0 immediately, before the next edge.
- **Single store:** store addr 0x10, data 0xAB, then idle.
  - Next cycle: `mem_memWrite`=1, `mem_address`=2, `mem_writeData`=0xAB.
  - Following cycle: `empty`=1.
- **Full / stall, DEPTH=4:** five consecutive stores to 0x00, 0x08, 0x10, 0x18, 0x20.
  - Cycle 5: `stall`=1, `mem_memWrite`=1, `mem_address`=0.
  - Cycle 6: `stall`=0 and the fifth store is accepted.
  - Drains then occur in order 0, 1, 2, 3, 4.
- **Forwarding (FWD_EN):** stores 0x18←5 and 0x18←7 back-to-back, then a load from 0x18 with dmem holding 0.
  - `cpu_readData`=7, `mem_memWrite`=0.
- **Load miss:** load 0x30 with no matching entry, dmem word 6 = 0x55.
  - `cpu_readData`=0x55, `mem_memRead`=1, `mem_address`=6.
- **Reset with pending stores:** three stores pending, then assert `reset`.
  - `empty`=1, and no further `mem_memWrite` pulses after release.
